ps2_key_serializer: RTL and testbench

Converts the 11-bit `ps2_key` event word from `hps_io` back into a device-side PS/2 serial stream (`ps2_clk`/`ps2_data`). The stream is fed to the `pc8001m` core's native PS/2 keyboard receiver, whose inputs are currently unconnected. Each key event becomes a set-2 byte sequence (make, extended, break). The bytes are buffered in a FIFO and sent as standard 11-bit PS/2 frames at a programmable bit rate.

---
 rtl/ps2_key_serializer_if.sv | 31 +++
 rtl/ps2_key_serializer.sv | 218 +++++++++++++++++++++
 tb/tb_ps2_key_serializer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_serializer_if.sv
// ----------------------------------------------------------------------------
// ps2_key_serializer_if
//   Groups the key-event input and the device-side PS/2 outputs of
//   ps2_key_serializer so they travel together between the host and the core.
//
//   ps2_key  [10:0] host -> dut  {toggle, press, extended, set-2 scan code}
//   inhibit         host -> dut  hold off new frames while high
//   ps2_clk         dut  -> host serial clock, idle high
//   ps2_data        dut  -> host serial data, idle high
//   busy            dut  -> host frame/gap in progress or bytes still queued
//   overflow        dut  -> host sticky: a whole key event was dropped
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
interface ps2_key_serializer_if;
  logic [10:0] ps2_key;
  logic        inhibit;
  logic        ps2_clk;
  logic        ps2_data;
  logic        busy;
  logic        overflow;

  modport master (
    output ps2_key, inhibit,
    input  ps2_clk, ps2_data, busy, overflow
  );

  modport slave (
    input  ps2_key, inhibit,
    output ps2_clk, ps2_data, busy, overflow
  );
endinterface

// File: rtl/ps2_key_serializer.sv
// ----------------------------------------------------------------------------
// ps2_key_serializer
//   Turns hps_io key events back into a device-side PS/2 set-2 stream.
//   Each event becomes 1-3 bytes (E0, F0, code), queued in a byte FIFO and
//   sent as 11-bit frames (start, 8 data LSB first, odd parity, stop).
//
//   clk_sys   system clock
//   reset     synchronous, active-high
//   bus       ps2_key_serializer_if.slave (key word, inhibit, PS/2 outputs,
//             busy, overflow)
//
//   HALF_BIT  clk_sys cycles per PS/2 clock half-period
//   GAP       minimum idle cycles (clock and data high) between frames
//   FIFO_AW   log2 of the byte FIFO depth
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module ps2_key_serializer #(
  parameter int HALF_BIT = 1000,
  parameter int GAP      = 2000,
  parameter int FIFO_AW  = 4
) (
  input logic                 clk_sys,
  input logic                 reset,
  ps2_key_serializer_if.slave bus
);

  localparam int DEPTH  = 1 << FIFO_AW;
  localparam int PH_MAX = (HALF_BIT > GAP) ? HALF_BIT : GAP;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0] HALF_LAST = PH_W'(HALF_BIT - 1);
  // IDLE always costs one cycle before the next start, so GAP_WAIT is one
  // cycle shorter than GAP to make the high-idle stretch exactly GAP cycles.
  localparam logic [PH_W-1:0] GAP_LAST  = PH_W'((GAP > 1) ? GAP - 2 : 0);

  typedef enum logic [1:0] {S_IDLE, S_BIT_HI, S_BIT_LO, S_GAP_WAIT} state_e;

  // Event detect / encoder
  logic [10:0]        key_q, key_d;
  logic               toggle_ref_q, toggle_ref_d;
  logic [23:0]        enc_buf_q, enc_buf_d;   // next byte to push in [7:0]
  logic [1:0]         enc_cnt_q, enc_cnt_d;   // bytes still to push
  logic               overflow_q, overflow_d;
  logic [23:0]        seq;
  logic [1:0]         seq_len;
  logic               accept;

  // FIFO
  logic [7:0]         fifo_mem [DEPTH];
  logic [FIFO_AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [FIFO_AW:0]   count, free;
  logic               empty, full, push, pop;
  logic [7:0]         rdata;

  // Serializer
  state_e             state_q, state_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic [10:0]        shift_q, shift_d;       // current bit in [0]
  logic               ps2_clk_q, ps2_clk_d;
  logic               ps2_data_q, ps2_data_d;

  assign count = wptr_q - rptr_q;
  assign free  = (FIFO_AW+1)'(DEPTH) - count;
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                 (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
  assign rdata = fifo_mem[rptr_q[FIFO_AW-1:0]];
  assign push  = (enc_cnt_q != 2'd0) && !full;

  // Byte sequence for the registered key word: E0 first, then F0, then code.
  always_comb begin
    seq     = {16'h0000, key_q[7:0]};
    seq_len = 2'd1;
    if (key_q[8] && !key_q[9]) begin
      seq     = {key_q[7:0], 8'hF0, 8'hE0};
      seq_len = 2'd3;
    end else if (key_q[8]) begin
      seq     = {8'h00, key_q[7:0], 8'hE0};
      seq_len = 2'd2;
    end else if (!key_q[9]) begin
      seq     = {8'h00, key_q[7:0], 8'hF0};
      seq_len = 2'd2;
    end
  end

  assign accept = (enc_cnt_q == 2'd0) && (key_q[10] != toggle_ref_q);

  // NOTE: every signal gets a default at the top of a combinational block so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    key_d        = bus.ps2_key;
    toggle_ref_d = toggle_ref_q;
    enc_buf_d    = enc_buf_q;
    enc_cnt_d    = enc_cnt_q;
    overflow_d   = overflow_q;
    if (accept) begin
      toggle_ref_d = key_q[10];
      // All-or-nothing: a sequence that does not fit is dropped whole.
      if (free < (FIFO_AW+1)'(seq_len)) begin
        overflow_d = 1'b1;
      end else begin
        enc_buf_d = seq;
        enc_cnt_d = seq_len;
      end
    end else if (push) begin
      enc_buf_d = {8'h00, enc_buf_q[23:8]};
      enc_cnt_d = enc_cnt_q - 2'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ps2_clk_d  = ps2_clk_q;
    ps2_data_d = ps2_data_q;
    pop        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty && !bus.inhibit) begin
          pop        = 1'b1;
          shift_d    = {1'b1, ~^rdata, rdata, 1'b0};
          ps2_data_d = 1'b0;
          ps2_clk_d  = 1'b1;
          bit_cnt_d  = 4'd0;
          phase_d    = '0;
          state_d    = S_BIT_HI;
        end
      end
      S_BIT_HI: begin
        if (phase_q == HALF_LAST) begin
          phase_d   = '0;
          ps2_clk_d = 1'b0;
          state_d   = S_BIT_LO;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      S_BIT_LO: begin
        if (phase_q == HALF_LAST) begin
          phase_d   = '0;
          ps2_clk_d = 1'b1;
          if (bit_cnt_q == 4'd10) begin
            ps2_data_d = 1'b1;
            state_d    = S_GAP_WAIT;
          end else begin
            // Data only moves together with the clock rise.
            bit_cnt_d  = bit_cnt_q + 4'd1;
            shift_d    = {1'b1, shift_q[10:1]};
            ps2_data_d = shift_q[1];
            state_d    = S_BIT_HI;
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      S_GAP_WAIT: begin
        if (phase_q == GAP_LAST) begin
          phase_d = '0;
          state_d = S_IDLE;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign wptr_d = wptr_q + (FIFO_AW+1)'(push);
  assign rptr_d = rptr_q + (FIFO_AW+1)'(pop);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      key_q        <= bus.ps2_key;
      toggle_ref_q <= bus.ps2_key[10];  // current word is not an event
      enc_buf_q    <= '0;
      enc_cnt_q    <= '0;
      overflow_q   <= 1'b0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      state_q      <= S_IDLE;
      phase_q      <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '1;
      ps2_clk_q    <= 1'b1;
      ps2_data_q   <= 1'b1;
    end else begin
      key_q        <= key_d;
      toggle_ref_q <= toggle_ref_d;
      enc_buf_q    <= enc_buf_d;
      enc_cnt_q    <= enc_cnt_d;
      overflow_q   <= overflow_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      state_q      <= state_d;
      phase_q      <= phase_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      ps2_clk_q    <= ps2_clk_d;
      ps2_data_q   <= ps2_data_d;
    end
  end

  // NOTE: the storage array has no reset; emptiness is defined by the
  // pointers alone, so clearing it would only cost logic.
  always_ff @(posedge clk_sys) begin
    if (push) fifo_mem[wptr_q[FIFO_AW-1:0]] <= enc_buf_q[7:0];
  end

  assign bus.ps2_clk  = ps2_clk_q;
  assign bus.ps2_data = ps2_data_q;
  assign bus.overflow = overflow_q;
  assign bus.busy     = (enc_cnt_q != 2'd0) || !empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_ps2_key_serializer.sv
// ----------------------------------------------------------------------------
// tb_ps2_key_serializer
//   Random and directed key events. Each event is expanded into its set-2
//   byte list by a reference model and queued; an independent monitor decodes
//   the PS/2 line (bits on ps2_clk falls), pops the queue and compares bytes,
//   parity, framing and timing.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ps2_key_serializer;
  localparam int HB      = 10;
  localparam int GP      = 30;
  localparam int AW      = 4;
  localparam int DEPTH   = 1 << AW;
  localparam int FRAME   = 22 * HB;
  localparam int SPACING = FRAME + GP;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  ps2_key_serializer_if bus();

  ps2_key_serializer #(.HALF_BIT(HB), .GAP(GP), .FIFO_AW(AW)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model state: bytes the DUT FIFO should hold, in order.
  logic [7:0] exp_q[$];
  bit         model_ovf = 1'b0;

  // Monitor state
  bit          frame_active = 1'b0;
  int          nbits = 0;
  int          t_start = 0;
  int          last_start = 0;
  bit          have_last = 1'b0;
  bit          have_exp = 1'b0;
  logic [7:0]  cur_exp = 8'h00;
  logic [10:0] bits = '0;
  logic [10:0] last_bits = '0;
  int          frames_started = 0;
  int          frames_done = 0;
  int          starts_q[$];
  logic        prev_clk = 1'b1, prev_data = 1'b1, mc, md;

  always @(negedge clk_sys) begin
    if (reset) begin
      frame_active = 1'b0;
      nbits        = 0;
      have_last    = 1'b0;
      prev_clk     = 1'b1;
      prev_data    = 1'b1;
    end else begin
      mc = bus.ps2_clk;
      md = bus.ps2_data;
      if (!frame_active && prev_clk && mc && prev_data && !md) begin
        frame_active = 1'b1;
        nbits        = 0;
        t_start      = cyc;
        frames_started++;
        starts_q.push_back(cyc);
        if (have_last) check("start_spacing_min", int'((cyc - last_start) >= SPACING), 1);
        last_start = cyc;
        have_last  = 1'b1;
        have_exp   = (exp_q.size() != 0);
        check("frame_expected", int'(have_exp), 1);
        if (have_exp) cur_exp = exp_q.pop_front();
      end else if (md != prev_data && !(!prev_clk && mc)) begin
        check("data_edge_off_clk_rise", int'(md), int'(prev_data));
      end
      if (prev_clk && !mc) begin
        if (!frame_active) begin
          check("clk_fall_outside_frame", 0, 1);
        end else if (nbits < 11) begin
          check("clk_fall_time", cyc - t_start, HB * (2 * nbits + 1));
          bits[nbits] = md;
          nbits++;
          if (nbits == 11) begin
            last_bits = bits;
            check("start_bit", int'(bits[0]), 0);
            check("stop_bit", int'(bits[10]), 1);
            if (have_exp) begin
              check("data_byte", int'(bits[8:1]), int'(cur_exp));
              check("odd_parity", int'(bits[9]), int'(($countones(cur_exp) % 2) == 0));
            end
          end
        end
      end
      if (!prev_clk && mc && frame_active && nbits == 11) begin
        check("frame_length", cyc - t_start, FRAME);
        check("data_idle_after_frame", int'(md), 1);
        frame_active = 1'b0;
        frames_done++;
      end
      prev_clk  = mc;
      prev_data = md;
    end
  end

  // Toggle bit 10 with a new event; model expands it and applies the
  // all-or-nothing free-space rule. Returns the cycle index of the toggle.
  task automatic send_event(input bit press, input bit ext, input logic [7:0] code,
                            output int t_tog);
    int len;
    @(posedge clk_sys); #1;
    bus.ps2_key = {~bus.ps2_key[10], press, ext, code};
    t_tog = cyc;
    len = 1 + int'(ext) + int'(!press);
    if (DEPTH - exp_q.size() < len) begin
      model_ovf = 1'b1;
    end else begin
      if (ext)    exp_q.push_back(8'hE0);
      if (!press) exp_q.push_back(8'hF0);
      exp_q.push_back(code);
    end
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    @(negedge clk_sys);
    while ((exp_q.size() != 0 || frame_active || bus.busy) && n < 30000) begin
      @(negedge clk_sys);
      n++;
    end
    check({"drain_", tag}, int'(n < 30000), 1);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, n, s0, f0, r;
    bit p, e;
    logic [7:0] c;

    bus.ps2_key = 11'h400;
    bus.inhibit = 1'b0;

    // Reset idle with toggle bit high: no event afterwards.
    repeat (4) @(posedge clk_sys);
    #1 reset = 1'b0;
    @(negedge clk_sys);
    check("rst_ps2_clk", int'(bus.ps2_clk), 1);
    check("rst_ps2_data", int'(bus.ps2_data), 1);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_overflow", int'(bus.overflow), 0);
    repeat (200) @(negedge clk_sys);
    check("rst_no_frame", frames_started, 0);
    check("rst_idle_busy", int'(bus.busy), 0);

    // Make A (0x1C): latency, busy rise, exact bit pattern.
    send_event(1'b1, 1'b0, 8'h1C, t);
    repeat (2) @(negedge clk_sys);
    check("busy_before_accept", int'(bus.busy), 0);
    @(negedge clk_sys);
    check("busy_after_accept", int'(bus.busy), 1);
    wait_drain("make_a");
    // Toggle registered at edge N = t+1; start bit driven at N+3.
    check("start_latency", starts_q[starts_q.size()-1] - t, 4);
    check("make_a_bits", int'(last_bits), 11'h438);
    check("make_a_busy_low", int'(bus.busy), 0);

    // Extended break of right arrow: E0, F0, 74 back to back.
    s0 = starts_q.size();
    send_event(1'b0, 1'b1, 8'h74, t);
    wait_drain("ext_break");
    check("ext_break_frames", starts_q.size() - s0, 3);
    if (starts_q.size() - s0 == 3) begin
      check("ext_spacing_1", starts_q[s0+1] - starts_q[s0], SPACING);
      check("ext_spacing_2", starts_q[s0+2] - starts_q[s0+1], SPACING);
    end

    // Random events, kept below the FIFO limit.
    for (int i = 0; i < 14; i++) begin
      n = 0;
      while (exp_q.size() > 10 && n < 5000) begin
        @(negedge clk_sys);
        n++;
      end
      p = 1'($urandom_range(0, 1));
      e = 1'($urandom_range(0, 1));
      c = 8'($urandom_range(0, 255));
      send_event(p, e, c, t);
      repeat ($urandom_range(6, 150)) @(posedge clk_sys);
    end
    wait_drain("random");
    check("random_no_overflow", int'(bus.overflow), 0);

    // Inhibit during bit 4: the frame finishes, the next one waits.
    s0 = frames_started;
    f0 = frames_done;
    send_event(1'b1, 1'b1, 8'h6B, t);
    n = 0;
    while (!(frame_active && nbits == 5) && n < 2000) begin
      @(negedge clk_sys);
      n++;
    end
    check("inh_reach_bit4", int'(n < 2000), 1);
    @(posedge clk_sys); #1 bus.inhibit = 1'b1;
    repeat (FRAME + 3 * GP + 50) @(negedge clk_sys);
    check("inh_frame_completed", frames_done - f0, 1);
    check("inh_no_new_start", frames_started - s0, 1);
    @(posedge clk_sys); #1 bus.inhibit = 1'b0;
    r = cyc;
    n = 0;
    while (frames_started == s0 + 1 && n < 2000) begin
      @(negedge clk_sys);
      n++;
    end
    check("inh_release_start", starts_q[starts_q.size()-1] - r, 1);
    wait_drain("inhibit");

    // Overflow: 6 extended breaks into a 16-byte FIFO while inhibited.
    bus.inhibit = 1'b1;
    f0 = frames_done;
    for (int i = 0; i < 6; i++) begin
      send_event(1'b0, 1'b1, 8'h74, t);
      repeat (8) @(negedge clk_sys);
      check("ovf_flag", int'(bus.overflow), int'(model_ovf));
    end
    check("ovf_model_bytes", exp_q.size(), 15);
    @(posedge clk_sys); #1 bus.inhibit = 1'b0;
    wait_drain("overflow");
    check("ovf_frames_sent", frames_done - f0, 15);
    check("ovf_sticky", int'(bus.overflow), 1);

    // Reset during bit 6 low phase truncates the frame.
    send_event(1'b0, 1'b1, 8'h75, t);
    n = 0;
    while (!(frame_active && nbits == 7 && bus.ps2_clk == 1'b0) && n < 2000) begin
      @(negedge clk_sys);
      n++;
    end
    check("rst_mid_reach_bit6", int'(n < 2000), 1);
    @(posedge clk_sys); #1 reset = 1'b1;
    exp_q.delete();
    model_ovf = 1'b0;
    @(posedge clk_sys);
    @(negedge clk_sys);
    check("rst_mid_ps2_clk", int'(bus.ps2_clk), 1);
    check("rst_mid_ps2_data", int'(bus.ps2_data), 1);
    check("rst_mid_busy", int'(bus.busy), 0);
    check("rst_mid_overflow", int'(bus.overflow), 0);
    @(posedge clk_sys); #1 reset = 1'b0;
    s0 = frames_started;
    repeat (3 * SPACING) @(negedge clk_sys);
    check("rst_mid_no_frames", frames_started - s0, 0);
    check("rst_mid_idle_busy", int'(bus.busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
